// File: rtl/mul_pipe_pkg.sv
// Shared constants, payload type and operand-extension helper for mul_pipe.
// Build option: MUL_PIPE_ACC_EN adds the running accumulator.
package mul_pipe_pkg;

    localparam int W_MIN      = 2;
    localparam int W_MAX      = 32;
    localparam int STAGES_MIN = 2;
    localparam int STAGES_MAX = 8;
    localparam int PW_MAX     = 2 * W_MAX;

    // Per-stage payload. The product field is sized for the widest
    // operand. Narrower instances use the low 2*W bits and tie the rest to zero.
    typedef struct packed {
        logic              valid;
        logic [PW_MAX-1:0] product;
        logic              acc_clr;
    } stage_t;

    // Widen a w-bit operand to w+1 bits. The result is sign-extended when sgn is set
    // and zero-extended otherwise. Bits above position w repeat the fill bit, so the
    // caller can take bits [w:0].
    function automatic logic [W_MAX:0] ext_op(input logic [W_MAX-1:0] x,
                                              input logic             sgn,
                                              input int               w);
        logic [W_MAX:0] r;
        logic           fill;
        fill = sgn & x[w-1];
        r    = '0;
        for (int i = 0; i < W_MAX; i++) begin
            r[i] = (i < w) ? x[i] : fill;
        end
        r[W_MAX] = fill;
        return r;
    endfunction

endpackage

// File: rtl/mul_core.sv
// Combinational (W+1) x (W+1) signed multiplier, full 2W+2-bit result.
// Build option: none (MUL_PIPE_ACC_EN does not affect this file).
module mul_core
    import mul_pipe_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W:0]     x,
    input  logic [W:0]     y,
    output logic [2*W+1:0] prod
);

    logic signed [2*W+1:0] xs;
    logic signed [2*W+1:0] ys;

    // Sign-extend both operands to the result width before multiplying. The low
    // 2W+2 bits of the product are then exact.
    assign xs   = {{(W+1){x[W]}}, x};
    assign ys   = {{(W+1){y[W]}}, y};
    assign prod = xs * ys;

endmodule

// File: rtl/mul_pipe.sv
// Pipelined W x W multiplier with per-operand signedness and a global-stall
// valid/ready handshake. Latency is STAGES cycles.
// Build option: define MUL_PIPE_ACC_EN to add the acc_clr input and a wrapping
// 2W-bit accumulator. With the option, p shows the running sum.
module mul_pipe
    import mul_pipe_pkg::*;
#(
    parameter int W      = 8,
    parameter int STAGES = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic           sgn_a,
    input  logic           sgn_b,
`ifdef MUL_PIPE_ACC_EN
    input  logic           acc_clr,
`endif
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] p
);

    if (W < W_MIN || W > W_MAX) begin : g_bad_w
        $error("mul_pipe: W out of range");
    end
    if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
        $error("mul_pipe: STAGES out of range");
    end

    // Handshake: an input transfer happens on an edge where in_valid & in_ready.
    // An output transfer happens on an edge where out_valid & out_ready.
    // The stall is global. A held result (out_valid & ~out_ready) freezes every stage,
    // and in_ready drops in the same cycle. Raising out_ready clears the stall
    // combinationally, so the output drain and a new accept can share one edge.
    logic stall;

    logic           s1_valid;
    logic [W-1:0]   s1_a;
    logic [W-1:0]   s1_b;
    logic           s1_sgn_a;
    logic           s1_sgn_b;
    logic           s1_clr;

    logic [W_MAX:0] ext_a_full;
    logic [W_MAX:0] ext_b_full;
    logic [W:0]     ext_a;
    logic [W:0]     ext_b;
    logic [2*W+1:0] prod_full;
    logic [2*W-1:0] prod;

    stage_t         stage_in [2:STAGES];
    stage_t         last_load;
    stage_t         pipe     [2:STAGES];

    assign stall     = out_valid & ~out_ready;
    assign in_ready  = ~stall;
    assign out_valid = pipe[STAGES].valid;
    assign p         = pipe[STAGES].product[2*W-1:0];

    // Stage 1: capture the operands only on accept. An idle cycle loads a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_sgn_a <= 1'b0;
            s1_sgn_b <= 1'b0;
        end else if (!stall) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a     <= a;
                s1_b     <= b;
                s1_sgn_a <= sgn_a;
                s1_sgn_b <= sgn_b;
            end
        end
    end

`ifdef MUL_PIPE_ACC_EN
    // Stage 1 clear flag. It is captured with the operands.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_clr <= 1'b0;
        end else if (!stall && in_valid) begin
            s1_clr <= acc_clr;
        end
    end
`else
    assign s1_clr = 1'b0;
`endif

    assign ext_a_full = ext_op(W_MAX'(s1_a), s1_sgn_a, W);
    assign ext_b_full = ext_op(W_MAX'(s1_b), s1_sgn_b, W);
    assign ext_a      = ext_a_full[W:0];
    assign ext_b      = ext_b_full[W:0];

    mul_core #(.W(W)) u_core (
        .x    (ext_a),
        .y    (ext_b),
        .prod (prod_full)
    );

    assign prod = prod_full[2*W-1:0];

    // Value offered to each stage on the next unstalled edge.
    always_comb begin
        for (int k = 2; k <= STAGES; k++) begin
            stage_in[k] = '0;
        end
        stage_in[2] = {s1_valid, PW_MAX'(prod), s1_clr};
        for (int k = 3; k <= STAGES; k++) begin
            stage_in[k] = pipe[k-1];
        end
    end

`ifdef MUL_PIPE_ACC_EN
    logic [2*W-1:0] acc_q;
    logic [2*W-1:0] acc_next;
    logic [2*W-1:0] entering;

    assign entering = stage_in[STAGES].product[2*W-1:0];
    assign acc_next = stage_in[STAGES].acc_clr ? entering : acc_q + entering;

    // The accumulator steps once per transaction entering the last stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
        end else if (!stall && stage_in[STAGES].valid) begin
            acc_q <= acc_next;
        end
    end

    // The last stage carries the new accumulator value instead of the raw product.
    always_comb begin
        last_load         = stage_in[STAGES];
        last_load.product = PW_MAX'(acc_next);
    end
`else
    // The last stage carries the raw product.
    always_comb begin
        last_load = stage_in[STAGES];
    end
`endif

    // Stages 2..STAGES shift together and hold as a block while stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 2; k <= STAGES; k++) begin
                pipe[k] <= '0;
            end
        end else if (!stall) begin
            for (int k = 2; k < STAGES; k++) begin
                pipe[k] <= stage_in[k];
            end
            pipe[STAGES] <= last_load;
        end
    end

    // Bits that exist only because the shared types are sized for the widest case.
    logic unused_misc;
    assign unused_misc = ^{prod_full[2*W+1:2*W], pipe[STAGES].acc_clr};

    if (W < W_MAX) begin : g_unused_hi
        logic unused_hi;
        assign unused_hi = ^{ext_a_full[W_MAX:W+1], ext_b_full[W_MAX:W+1],
                             pipe[STAGES].product[PW_MAX-1:2*W]};
    end

endmodule

// File: doc/mul_pipe.md
Name: mul_pipe

Overview:
Parametrised, pipelined W x W multiplier. It is the next generation of our registered 8x8 multiplier wrapper.
- Adds configurable width and latency.
- Adds a per-transaction signed/unsigned mode for each operand.
- Adds a valid/ready handshake with backpressure on both sides.
Sits between operand producers and datapath consumers (filters, MAC chains) wherever a multiply crosses a timing boundary.

Parameters:
W, 8, operand width in bits (2..32).
STAGES, 3, total latency in cycles from input acceptance to out_valid (2..8).

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset
in_valid  input  1  operand transaction present
in_ready  output  1  block can accept the transaction this cycle
a  input  W  operand A
b  input  W  operand B
sgn_a  input  1  1 = a is two's complement, 0 = unsigned
sgn_b  input  1  1 = b is two's complement, 0 = unsigned
out_valid  output  1  p holds a valid result
out_ready  input  1  consumer accepts p this cycle
p  output  2W  product, low 2W bits of the exact result

Behaviour:
- Reset: rst low clears everything asynchronously.
  - All stage valid bits, operand registers, pipeline data and p go to 0.
  - out_valid = 0; in_ready = 1 once rst is released.
- Pipeline structure:
  - Stage 1 registers a, b, sgn_a and sgn_b.
  - The product is formed after stage 1 and carried through stages 2..STAGES.
  - p and out_valid are the stage-STAGES registers.
- Arithmetic:
  - Extend each operand to W+1 bits: sign-extend if its sgn flag is 1, zero-extend if 0.
  - Multiply the two extended operands signed; the result is 2W+2 bits.
  - p = low 2W bits. All four sign combinations are exact in 2W bits.
- Handshake: global stall.
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall (combinational).
  - Accept = in_valid & in_ready. On accept, stage 1 loads the operands with valid = 1.
  - If in_ready = 1 and in_valid = 0, stage 1 loads valid = 0 (a bubble).
  - When not stalled, every stage shifts forward by one each cycle.
  - When stalled, all stages and p hold.
  - A transfer completes when out_valid & out_ready.
- Latency and throughput:
  - Unstalled, a result accepted at edge N appears with out_valid = 1 after edge N+STAGES-1.
  - That is STAGES cycles from the in_valid cycle to the out_valid cycle.
  - Throughput is one result per cycle. Bubbles are not compressed.
- Ordering: results leave in acceptance order. No drops, no duplicates.
- Boundary conditions:
  - out_ready held low with the pipeline full: in_ready stays 0 and p stays stable until out_ready rises.
  - out_ready and in_valid both asserted in a stalled cycle: out_ready removes the stall, so the shift and the accept happen on the same edge.
  - in_valid low: p is don't-care while out_valid = 0, but the data registers must not X-propagate after reset.
  - Reset mid-operation discards all in-flight transactions. No result emerges after rst is released.
- Operands and flags are sampled only on accept. They may change freely otherwise.

Optional Feature:
MUL_PIPE_ACC_EN
- Defined:
  - Adds input acc_clr (1 bit), captured with the operands on accept.
  - An accumulator register (2W bits, wraps modulo 2^2W) is updated when a transaction enters stage STAGES.
  - acc_clr = 1: acc = product. acc_clr = 0: acc = acc + product.
  - p outputs the new acc value instead of the raw product.
  - Stalls hold acc. Reset clears acc to 0.
- Undefined: no acc_clr port and no accumulator; p is the raw product.

Decomposition:
- Package mul_pipe_pkg:
  - Stage count bounds and the W range check constant.
  - Function ext_op(x, sgn, W) for the W+1-bit extension.
  - Struct type for the per-stage payload {valid, product, acc_clr}.
- Sub-module mul_core: a combinational (W+1) x (W+1) signed multiplier, instanced once after stage 1.
- The pipeline and handshake stay in mul_pipe.

Test Plan:
1. W=8, STAGES=3, unsigned: a=255, b=255 -> p=16'hFE01 with out_valid exactly 3 cycles after the in_valid cycle.
2. Signed both: a=8'hFF (-1), b=8'hFF -> p=16'h0001. a=8'h80, b=8'h80 (-128 x -128) -> p=16'h4000.
3. Mixed sign: a=8'hFE (-2, signed), b=8'hFF (255, unsigned) -> p=16'hFE02 (-510).
4. Backpressure: stream 10 transactions (a=i, b=3) with out_ready low for cycles 4..9.
   -> in_ready=0 during the stall, p stable, and all 10 results 3*i delivered in order with none lost.
5. Reset mid-stream: drop rst for 1 cycle with 3 transactions in flight.
   -> out_valid=0 immediately (asynchronous), no stale results afterwards, and the next accepted pair gives the correct product.
6. With MUL_PIPE_ACC_EN: feed (2,3, clr=1), (4,5, clr=0), (1,1, clr=1) -> p sequence 6, 26, 1.
